// File: rtl/ice_cmd_sequencer.sv
// ice_cmd_sequencer: buffers a command frame written byte by byte, sends it to
// a UART transmitter, counts the response bytes (with a receive timeout),
// holds an inter-frame gap, then pulses done and empties the buffer.
//
// Handshake wr_en/wr_ready: a byte is taken on any rising edge where wr_en and
// wr_ready are both high. In IDLE with the buffer full, wr_en drops the byte
// and sets the sticky overflow flag. Outside IDLE wr_en has no effect at all.
module ice_cmd_sequencer #(
    parameter int DEPTH      = 32,     // power of two, 2..256
    parameter int RX_TIMEOUT = 65535,  // >= 1
    parameter int GAP_CYCLES = 1000    // >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic [15:0] exp_rx,
    input  logic        start,
    output logic [7:0]  tx_data,
    output logic        tx_latch,
    input  logic        tx_empty,
    input  logic [7:0]  rx_data,
    input  logic        rx_latch,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        overflow,
    output logic [15:0] rx_count,
    output logic [7:0]  rx_first,
    output logic [2:0]  state_dbg
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RXT_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [RXT_W-1:0] RX_LAST  = RXT_W'(RX_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_LOAD = 3'd1,
        TX_WAIT = 3'd2,
        RX_WAIT = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   tx_left;
    logic [15:0]        exp_q;
    logic [RXT_W-1:0]   rx_timer;
    logic [GAP_W-1:0]   gap_timer;
    logic               tx_armed;
    logic               tx_empty_q;
    logic               rx_latch_q;
    logic [7:0]         tx_data_q;
    logic               tx_latch_q;
    logic               done_q;

    logic               full;
    logic               wr_accept;
    logic               tx_edge;
    logic               rx_edge;
    logic               rx_window;
    logic [15:0]        rx_count_nxt;

    assign full      = (count == FULL_CNT);
    assign wr_accept = (state == IDLE) && wr_en && !full;
    assign tx_edge   = tx_empty && !tx_empty_q;
    assign rx_edge   = rx_latch && !rx_latch_q;
    assign rx_window = (state == TX_WAIT) || (state == RX_WAIT);

    // Response byte count including an edge seen this cycle, saturating.
    always_comb begin
        rx_count_nxt = rx_count;
        if (rx_window && rx_edge && (rx_count != 16'hFFFF)) begin
            rx_count_nxt = rx_count + 16'd1;
        end
    end

    // Frame buffer storage; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Sequencer FSM with its pointers, timers, status flags and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_left    <= '0;
            exp_q      <= '0;
            rx_timer   <= '0;
            gap_timer  <= '0;
            tx_armed   <= 1'b0;
            tx_empty_q <= 1'b0;
            rx_latch_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_latch_q <= 1'b0;
            done_q     <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            rx_count   <= '0;
            rx_first   <= 8'h00;
        end else begin
            tx_latch_q <= 1'b0;
            done_q     <= 1'b0;
            tx_empty_q <= tx_empty;
            rx_latch_q <= rx_latch;

            if (rx_window) begin
                rx_count <= rx_count_nxt;
                if (rx_edge && (rx_count == 16'd0)) begin
                    rx_first <= rx_data;
                end
            end

            case (state)
                IDLE: begin
                    if (wr_accept) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        count  <= count + CNT_W'(1);
                    end else if (wr_en && full) begin
                        overflow <= 1'b1;
                    end
                    if (start && (count != '0)) begin
                        exp_q    <= exp_rx;
                        rx_count <= '0;
                        rx_first <= 8'h00;
                        timeout  <= 1'b0;
                        rx_timer <= '0;
                        tx_left  <= count + CNT_W'(wr_accept);
                        state    <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    tx_data_q  <= mem[rd_ptr];
                    tx_latch_q <= 1'b1;
                    rd_ptr     <= rd_ptr + PTR_W'(1);
                    tx_left    <= tx_left - CNT_W'(1);
                    tx_armed   <= 1'b0;
                    state      <= TX_WAIT;
                end
                TX_WAIT: begin
                    // The cycle of the load strobe is skipped so a stale idle
                    // flag from the UART cannot be taken as completion.
                    if (!tx_armed) begin
                        tx_armed <= 1'b1;
                    end else if (tx_edge) begin
                        if (tx_left != '0) begin
                            state <= TX_LOAD;
                        end else if (exp_q == 16'd0) begin
                            gap_timer <= '0;
                            state     <= GAP;
                        end else begin
                            rx_timer <= '0;
                            state    <= RX_WAIT;
                        end
                    end
                end
                RX_WAIT: begin
                    // Completion is checked first so a final byte arriving on
                    // the expiry cycle still counts as a good response.
                    if (rx_count_nxt >= exp_q) begin
                        gap_timer <= '0;
                        state     <= GAP;
                    end else if (rx_timer == RX_LAST) begin
                        timeout   <= 1'b1;
                        gap_timer <= '0;
                        state     <= GAP;
                    end else begin
                        rx_timer <= rx_timer + RXT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_timer == GAP_LAST) begin
                        state <= DONE;
                    end else begin
                        gap_timer <= gap_timer + GAP_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even mid-frame.
    assign wr_ready  = !reset && (state == IDLE) && !full;
    assign busy      = !reset && (state != IDLE);
    assign tx_latch  = tx_latch_q && !reset;
    assign tx_data   = reset ? 8'h00 : tx_data_q;
    assign done      = done_q && !reset;
    assign state_dbg = state;

endmodule

// File: doc/ice_cmd_sequencer.md
ICE_CMD_SEQUENCER -- requirements
Module: ice_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, 32, command-frame buffer depth in bytes, power of two, 2..256.
REQ-002 Parameter: RX_TIMEOUT, 65535, max cycles allowed in RX_WAIT.
REQ-003 Parameter: GAP_CYCLES, 1000, idle cycles inserted after each frame before DONE.
REQ-004 Port: clk, input, 1, single system clock; all logic on rising edge.
REQ-005 Port: reset, input, 1, synchronous, active-high reset.
REQ-006 Port: wr_en, input, 1, pushes wr_data into the frame buffer.
REQ-007 Port: wr_data, input, 8, command byte.
REQ-008 Port: wr_ready, output, 1, high when IDLE and buffer not full.
REQ-009 Port: exp_rx, input, 16, expected response byte count, sampled on start.
REQ-010 Port: start, input, 1, one-cycle request to transmit the buffered frame.
REQ-011 Port: tx_data, output, 8, byte to the UART transmitter.
REQ-012 Port: tx_latch, output, 1, one-cycle load strobe to the UART.
REQ-013 Port: tx_empty, input, 1, UART transmitter idle flag.
REQ-014 Port: rx_data, input, 8, UART received byte.
REQ-015 Port: rx_latch, input, 1, UART receive strobe; may stay high for several cycles.
REQ-016 Port: busy, output, 1, high in any state other than IDLE.
REQ-017 Port: done, output, 1, one-cycle pulse at frame completion.
REQ-018 Port: timeout, output, 1, status for the last frame; valid from done until the next start.
REQ-019 Port: overflow, output, 1, sticky flag for a write dropped because the buffer was full.
REQ-020 Port: rx_count, output, 16, response bytes counted for the current or last frame.
REQ-021 Port: rx_first, output, 8, first response byte of the last frame (ACK/NAK code).

Function
REQ-022 States SHALL be IDLE, TX_LOAD, TX_WAIT, RX_WAIT, GAP and DONE.
REQ-023 IDLE: wr_en with wr_ready SHALL store the byte at the write pointer and increment the byte count.
REQ-024 IDLE: wr_en with the buffer full SHALL drop the byte and set overflow.
REQ-025 wr_en outside IDLE SHALL be ignored and SHALL NOT set overflow.
REQ-026 IDLE with start and count>0 SHALL latch exp_rx, clear rx_count and timeout, and go to TX_LOAD next cycle.
REQ-027 start with count=0, or outside IDLE, SHALL be ignored.
REQ-028 TX_LOAD SHALL drive tx_data with the buffer byte in write order, pulse tx_latch for exactly 1 cycle, and go to TX_WAIT.
REQ-029 TX_WAIT SHALL ignore tx_empty for the first cycle after tx_latch.
REQ-030 TX_WAIT SHALL then wait for a 0->1 edge of tx_empty.
REQ-031 On that edge TX_WAIT SHALL go to TX_LOAD if bytes remain.
REQ-032 Otherwise TX_WAIT SHALL go to RX_WAIT, or to GAP if latched exp_rx=0.
REQ-033 The first tx_latch SHALL occur 2 cycles after start is sampled.
REQ-034 rx_count SHALL increment only on rx_latch 0->1 edges; a multi-cycle high counts once.
REQ-035 rx_count SHALL saturate at 16'hFFFF.
REQ-036 rx_first SHALL capture rx_data on the first edge after start.
REQ-037 Edges SHALL be counted in TX_WAIT and in RX_WAIT.
REQ-038 RX_WAIT SHALL go to GAP once rx_count >= latched exp_rx.
REQ-039 RX_WAIT SHALL set timeout and go to GAP after RX_TIMEOUT cycles in RX_WAIT.
REQ-040 If the final byte arrives in the same cycle the timer expires, completion SHALL win and timeout stays 0.
REQ-041 GAP SHALL last GAP_CYCLES cycles, then go to DONE.
REQ-042 DONE SHALL pulse done for 1 cycle, empty the buffer (pointers and count = 0), and return to IDLE.
REQ-043 Counters SHALL size from parameters with $clog2; pointers SHALL wrap modulo DEPTH.

Reset
REQ-044 reset SHALL return to IDLE next edge and clear buffer pointers and count, overflow, timeout, rx_count, rx_first and all timers.
REQ-045 During reset tx_latch and done SHALL be 0, tx_data SHALL be 8'h00, wr_ready SHALL be 0 and busy SHALL be 0.
REQ-046 Reset mid-frame SHALL abort with no further tx_latch and no done pulse.

Verification
REQ-047 Write 6d 0f 02 72 01, exp_rx=3, start, UART echoes 3 bytes 00 xx xx -> tx_latch x5 in order, rx_count=3, rx_first=00, timeout=0, done once after GAP_CYCLES.
REQ-048 RX_TIMEOUT=100, exp_rx=3, only 2 rx bytes arrive -> timeout=1, rx_count=2, done 100+GAP_CYCLES+1 cycles after RX_WAIT entry.
REQ-049 DEPTH=4, write 5 bytes -> overflow=1, only 4 bytes transmitted, wr_ready=0 after the 4th write.
REQ-050 exp_rx=0, 1-byte frame -> no RX_WAIT, done follows GAP; start with empty buffer -> busy stays 0.
REQ-051 rx_latch held high 5 cycles per byte -> each byte counts once; final byte coincident with timer expiry -> timeout=0.
REQ-052 Assert reset during the 3rd TX_WAIT -> busy=0 next cycle, no further tx_latch, no done, wr_ready=1 after reset.
